// File: rtl/bram_pkg.sv
// Shared constants and helpers for the true dual-port byte-enable block RAM.
package bram_pkg;

   localparam int WR_READ_FIRST  = 0;
   localparam int WR_WRITE_FIRST = 1;

   // Number of byte lanes in one word.
   function automatic int calc_nb(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/bram_tdp_byte_en_if.sv
// Two-port access bus of the byte-enable BRAM: requests from the masters, read data and flags back.
interface bram_tdp_byte_en_if #(
   parameter int addr_width = 10,
   parameter int data_width = 32,
   parameter int byte_width = 8
);
   import bram_pkg::*;

   localparam int NB = calc_nb(data_width, byte_width);

   logic                  en_a;
   logic [NB-1:0]         we_a;
   logic [addr_width-1:0] addr_a;
   logic [data_width-1:0] din_a;
   logic [data_width-1:0] dout_a;
   logic                  valid_a;

   logic                  en_b;
   logic [NB-1:0]         we_b;
   logic [addr_width-1:0] addr_b;
   logic [data_width-1:0] din_b;
   logic [data_width-1:0] dout_b;
   logic                  valid_b;

   logic                  collision;

   modport master (
      output en_a, we_a, addr_a, din_a,
      output en_b, we_b, addr_b, din_b,
      input  dout_a, valid_a, dout_b, valid_b, collision
   );

   modport slave (
      input  en_a, we_a, addr_a, din_a,
      input  en_b, we_b, addr_b, din_b,
      output dout_a, valid_a, dout_b, valid_b, collision
   );

endinterface

// File: rtl/bram_out_pipe.sv
// Read-data/valid output pipeline of one port, 1 or 2 register stages deep.
module bram_out_pipe #(
   parameter int data_width = 32,
   parameter int depth      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [data_width-1:0] in_data,
   output logic                  out_valid,
   output logic [data_width-1:0] out_data
);

   logic [data_width-1:0] s1_data_r;
   logic                  s1_valid_r;

   // First stage: captures read data only for enabled accesses, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data_r  <= {data_width{1'b0}};
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_data_r <= in_data;
         end else begin
            s1_data_r <= s1_data_r;
         end
      end
   end

   generate
      if (depth == 2) begin : g_two_stage
         logic [data_width-1:0] s2_data_r;
         logic                  s2_valid_r;

         // Second stage: free-running copy of stage one, never stalls.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_data_r  <= {data_width{1'b0}};
               s2_valid_r <= 1'b0;
            end else begin
               s2_data_r  <= s1_data_r;
               s2_valid_r <= s1_valid_r;
            end
         end

         assign out_data  = s2_data_r;
         assign out_valid = s2_valid_r;
      end else begin : g_one_stage
         assign out_data  = s1_data_r;
         assign out_valid = s1_valid_r;
      end
   endgenerate

endmodule

// File: rtl/bram_tdp_byte_en.sv
// True dual-port block RAM with byte write enables, selectable read-during-write mode,
// 1/2-cycle read latency and same-address collision reporting.
module bram_tdp_byte_en
   import bram_pkg::*;
#(
   parameter int addr_width   = 10,
   parameter int data_width   = 32,
   parameter int byte_width   = 8,
   parameter int read_latency = 1,
   parameter int wr_mode      = 0
) (
   input logic               clk,
   input logic               rst_n,
   bram_tdp_byte_en_if.slave bus
);

   localparam int NB    = calc_nb(data_width, byte_width);
   localparam int DEPTH = 2 ** addr_width;

   generate
      if ((data_width % byte_width) != 0) begin : g_bad_byte_width
         $error("bram_tdp_byte_en: data_width must be a multiple of byte_width");
      end
      if ((read_latency != 1) && (read_latency != 2)) begin : g_bad_latency
         $error("bram_tdp_byte_en: read_latency must be 1 or 2");
      end
      if ((wr_mode != WR_READ_FIRST) && (wr_mode != WR_WRITE_FIRST)) begin : g_bad_wr_mode
         $error("bram_tdp_byte_en: wr_mode must be 0 or 1");
      end
   endgenerate

   logic [data_width-1:0] mem_r [DEPTH];

   logic [NB-1:0]         lane_a_s;
   logic [NB-1:0]         lane_b_s;
   logic [NB-1:0]         lane_b_wr_s;
   logic                  same_addr_s;
   logic [data_width-1:0] old_a_s;
   logic [data_width-1:0] old_b_s;
   logic [data_width-1:0] rd_a_s;
   logic [data_width-1:0] rd_b_s;
   logic                  collision_r;

   assign lane_a_s    = bus.en_a ? bus.we_a : {NB{1'b0}};
   assign lane_b_s    = bus.en_b ? bus.we_b : {NB{1'b0}};
   assign same_addr_s = (bus.addr_a == bus.addr_b);
   // Port A owns lanes both ports write to the same word.
   assign lane_b_wr_s = lane_b_s & ~(same_addr_s ? lane_a_s : {NB{1'b0}});

   assign old_a_s = mem_r[bus.addr_a];
   assign old_b_s = mem_r[bus.addr_b];

   // Memory array with both byte-lane write paths.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (lane_a_s[i]) begin
            mem_r[bus.addr_a][i*byte_width +: byte_width] <= bus.din_a[i*byte_width +: byte_width];
         end
         if (lane_b_wr_s[i]) begin
            mem_r[bus.addr_b][i*byte_width +: byte_width] <= bus.din_b[i*byte_width +: byte_width];
         end
      end
   end

   // Read word per port: write-first merges only that port's own write into the old word.
   always_comb begin
      rd_a_s = old_a_s;
      rd_b_s = old_b_s;
      if (wr_mode == WR_WRITE_FIRST) begin
         for (int i = 0; i < NB; i++) begin
            if (lane_a_s[i]) begin
               rd_a_s[i*byte_width +: byte_width] = bus.din_a[i*byte_width +: byte_width];
            end else begin
               rd_a_s[i*byte_width +: byte_width] = old_a_s[i*byte_width +: byte_width];
            end
            if (lane_b_s[i]) begin
               rd_b_s[i*byte_width +: byte_width] = bus.din_b[i*byte_width +: byte_width];
            end else begin
               rd_b_s[i*byte_width +: byte_width] = old_b_s[i*byte_width +: byte_width];
            end
         end
      end else begin
         rd_a_s = old_a_s;
         rd_b_s = old_b_s;
      end
   end

   // Conflict flag: both ports on one word with at least one of them writing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collision_r <= 1'b0;
      end else begin
         collision_r <= bus.en_a && bus.en_b && same_addr_s && ((|lane_a_s) || (|lane_b_s));
      end
   end

   assign bus.collision = collision_r;

   bram_out_pipe #(
      .data_width (data_width),
      .depth      (read_latency)
   ) u_pipe_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.en_a),
      .in_data   (rd_a_s),
      .out_valid (bus.valid_a),
      .out_data  (bus.dout_a)
   );

   bram_out_pipe #(
      .data_width (data_width),
      .depth      (read_latency)
   ) u_pipe_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.en_b),
      .in_data   (rd_b_s),
      .out_valid (bus.valid_b),
      .out_data  (bus.dout_b)
   );

endmodule

// File: tb/tb_bram_tdp_byte_en.sv
// Bench: three BRAM variants (lat1/read-first, lat1/write-first, lat2/read-first) on shared stimulus,
// checked each cycle against an access-history model plus directed literal expectations.
module tb_bram_tdp_byte_en;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;
   localparam int HMAX  = 8192;
   localparam int ND    = 3;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic en_a   = 1'b0;
   logic en_b   = 1'b0;
   logic [NB-1:0] we_a   = 4'h0;
   logic [NB-1:0] we_b   = 4'h0;
   logic [AW-1:0] addr_a = 4'h0;
   logic [AW-1:0] addr_b = 4'h0;
   logic [DW-1:0] din_a  = 32'h0;
   logic [DW-1:0] din_b  = 32'h0;

   logic [DW-1:0] dout_a_w  [ND];
   logic [DW-1:0] dout_b_w  [ND];
   logic          valid_a_w [ND];
   logic          valid_b_w [ND];
   logic          col_w     [ND];

   int n_cmp  = 0;
   int n_bad  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int LAT  = (g == 2) ? 2 : 1;
      localparam int MODE = (g == 1) ? 1 : 0;

      bram_tdp_byte_en_if #(.addr_width(AW), .data_width(DW), .byte_width(8)) bus ();

      assign bus.en_a   = en_a;
      assign bus.we_a   = we_a;
      assign bus.addr_a = addr_a;
      assign bus.din_a  = din_a;
      assign bus.en_b   = en_b;
      assign bus.we_b   = we_b;
      assign bus.addr_b = addr_b;
      assign bus.din_b  = din_b;

      bram_tdp_byte_en #(
         .addr_width   (AW),
         .data_width   (DW),
         .byte_width   (8),
         .read_latency (LAT),
         .wr_mode      (MODE)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      assign dout_a_w[g]  = bus.dout_a;
      assign dout_b_w[g]  = bus.dout_b;
      assign valid_a_w[g] = bus.valid_a;
      assign valid_b_w[g] = bus.valid_b;
      assign col_w[g]     = bus.collision;
   end

   // ---------------- behavioural model: memory plus per-edge access history ----------------
   logic [DW-1:0] mem_m [DEPTH];
   bit            h_en_a [HMAX];
   bit            h_en_b [HMAX];
   bit            h_col  [HMAX];
   logic [DW-1:0] h_ra0  [HMAX];
   logic [DW-1:0] h_ra1  [HMAX];
   logic [DW-1:0] h_rb0  [HMAX];
   logic [DW-1:0] h_rb1  [HMAX];
   int            cyc      = 0;
   int            rst_mark = 0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [NB-1:0] we);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < NB; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) rst_mark <= cyc + 1;
      if (cyc + 1 < HMAX) begin
         h_en_a[cyc+1] <= rst_n && en_a;
         h_en_b[cyc+1] <= rst_n && en_b;
         h_col[cyc+1]  <= rst_n && en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
         h_ra0[cyc+1]  <= mem_m[addr_a];
         h_ra1[cyc+1]  <= merge(mem_m[addr_a], din_a, we_a);
         h_rb0[cyc+1]  <= mem_m[addr_b];
         h_rb1[cyc+1]  <= merge(mem_m[addr_b], din_b, we_b);
      end
      if (en_b && (|we_b)) mem_m[addr_b] <= merge(mem_m[addr_b], din_b, we_b);
      if (en_a && (|we_a))
         mem_m[addr_a] <= merge((en_b && addr_a == addr_b) ? merge(mem_m[addr_a], din_b, we_b)
                                                           : mem_m[addr_a], din_a, we_a);
   end

   // Output after edge k shows the newest enabled, post-reset access made at or before edge k-L+1.
   function automatic void expect_out(input int k, input int lat, input int mode, input bit port,
                                      output logic v, output logic [DW-1:0] d);
      int j;
      j = k - lat + 1;
      v = 1'b0;
      d = 32'h0;
      if (j > rst_mark) v = port ? h_en_b[j] : h_en_a[j];
      for (int t = j; t > rst_mark && t >= 1; t--) begin
         if (port ? h_en_b[t] : h_en_a[t]) begin
            if (port) d = mode ? h_rb1[t] : h_rb0[t];
            else      d = mode ? h_ra1[t] : h_ra0[t];
            break;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison of every variant against the model.
   always @(negedge clk) begin
      logic          v;
      logic [DW-1:0] d;
      if (chk_en && cyc >= 2 && cyc < HMAX) begin
         for (int g = 0; g < ND; g++) begin
            expect_out(cyc, (g == 2) ? 2 : 1, (g == 1) ? 1 : 0, 1'b0, v, d);
            chk($sformatf("dut%0d valid_a", g), {31'h0, valid_a_w[g]}, {31'h0, v});
            chk($sformatf("dut%0d dout_a", g), dout_a_w[g], d);
            expect_out(cyc, (g == 2) ? 2 : 1, (g == 1) ? 1 : 0, 1'b1, v, d);
            chk($sformatf("dut%0d valid_b", g), {31'h0, valid_b_w[g]}, {31'h0, v});
            chk($sformatf("dut%0d dout_b", g), dout_b_w[g], d);
            chk($sformatf("dut%0d collision", g), {31'h0, col_w[g]},
                {31'h0, (cyc > rst_mark) && h_col[cyc]});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
   endtask

   task automatic acc_a(input logic e, input logic [NB-1:0] w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      en_a = e; we_a = w; addr_a = ad; din_a = d;
   endtask

   task automatic acc_b(input logic e, input logic [NB-1:0] w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      en_b = e; we_b = w; addr_b = ad; din_b = d;
   endtask

   initial begin
      int vcount;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Preload: A5 pattern everywhere except the words later tests expect to start at zero.
      for (int a = 0; a < DEPTH; a++) begin
         acc_a(1'b1, 4'hF, 4'(a), (a == 5 || a == 7 || a == 9) ? 32'h0 : 32'hA5A5A5A5);
         tick();
      end
      idle();
      tick();

      // Test 1: reset while port A reads.
      acc_a(1'b1, 4'h0, 4'h0, 32'h0);
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("t1 dout_a in reset", dout_a_w[0], 32'h0);
      chk("t1 valid_a in reset", {31'h0, valid_a_w[0]}, 32'h0);
      tick();
      tick();
      chk("t1 dout_a held reset", dout_a_w[0], 32'h0);
      rst_n = 1'b1;
      tick();
      chk("t1 readback after reset", dout_a_w[0], 32'hA5A5A5A5);
      chk("t1 valid_a after reset", {31'h0, valid_a_w[0]}, 32'h1);

      // Test 2: byte-lane write.
      acc_a(1'b1, 4'hF, 4'h3, 32'h11223344); tick();
      acc_a(1'b1, 4'b0010, 4'h3, 32'hFFFFFFFF); tick();
      acc_a(1'b1, 4'h0, 4'h3, 32'h0); tick();
      chk("t2 byte merge", dout_a_w[0], 32'h1122FF44);
      chk("t2 valid_a", {31'h0, valid_a_w[0]}, 32'h1);
      idle(); tick();
      chk("t2 valid_a one cycle", {31'h0, valid_a_w[0]}, 32'h0);
      chk("t2 dout_a holds", dout_a_w[0], 32'h1122FF44);

      // Test 3: same-port read-during-write.
      acc_a(1'b1, 4'hF, 4'h5, 32'hDEADBEEF); tick();
      chk("t3 read-first", dout_a_w[0], 32'h0);
      chk("t3 write-first", dout_a_w[1], 32'hDEADBEEF);
      idle(); tick();

      // Test 4: write/write collision.
      acc_a(1'b1, 4'b0011, 4'h7, 32'hAAAAAAAA);
      acc_b(1'b1, 4'b0110, 4'h7, 32'hBBBBBBBB);
      tick();
      chk("t4 collision", {31'h0, col_w[0]}, 32'h1);
      idle(); tick();
      chk("t4 collision pulse", {31'h0, col_w[0]}, 32'h0);
      acc_a(1'b1, 4'h0, 4'h7, 32'h0); tick();
      chk("t4 merged word", dout_a_w[0], 32'h00BBAAAA);
      idle(); tick();

      // Test 5: write/read collision then read/read.
      acc_a(1'b1, 4'hF, 4'h9, 32'h12345678);
      acc_b(1'b1, 4'h0, 4'h9, 32'h0);
      tick();
      chk("t5 reader old rf", dout_b_w[0], 32'h0);
      chk("t5 reader old wf", dout_b_w[1], 32'h0);
      chk("t5 collision", {31'h0, col_w[0]}, 32'h1);
      acc_a(1'b1, 4'h0, 4'h9, 32'h0);
      tick();
      chk("t5 read/read no flag", {31'h0, col_w[0]}, 32'h0);
      chk("t5 reader new", dout_b_w[0], 32'h12345678);
      idle(); tick(); tick();

      // Test 6: latency-2 streaming reads on B.
      vcount = 0;
      for (int a = 0; a < DEPTH; a++) begin
         acc_b(1'b1, 4'h0, 4'(a), 32'h0);
         tick();
         if (valid_b_w[2]) vcount++;
         if (a == 4) chk("t6 lat2 addr3", dout_b_w[2], 32'h1122FF44);
      end
      idle();
      repeat (3) begin
         tick();
         if (valid_b_w[2]) vcount++;
      end
      chk("t6 valid_b count", 32'(vcount), 32'd16);

      for (int a = 0; a <= 8; a++) begin
         acc_b(1'b1, 4'h0, 4'(a), 32'h0);
         if (a < 8) tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("t6 valid_b drops", {31'h0, valid_b_w[2]}, 32'h0);
      chk("t6 dout_b cleared", dout_b_w[2], 32'h0);
      tick();
      idle();
      rst_n = 1'b1;
      tick(); tick();
      chk("t6 no stale valid", {31'h0, valid_b_w[2]}, 32'h0);
      chk("t6 no stale data", dout_b_w[2], 32'h0);

      // Randomized traffic, frequent same-address pairs.
      for (int i = 0; i < 3000; i++) begin
         en_a   = ($urandom_range(0, 3) != 0);
         en_b   = ($urandom_range(0, 3) != 0);
         we_a   = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         we_b   = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         addr_a = 4'($urandom_range(0, 15));
         addr_b = $urandom_range(0, 1) ? addr_a : 4'($urandom_range(0, 15));
         din_a  = $urandom();
         din_b  = $urandom();
         tick();
      end
      idle();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
